// File: rtl/para_ram_banked_if.sv
// para_ram_banked_if: flattened per-port request/response bus of the banked RAM.
// The master drives requests; the slave returns grants, read data and init status.
interface para_ram_banked_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 24,
   parameter int NUM_PORTS  = 2
);
   localparam int LANES = DATA_WIDTH / 8;
   logic [NUM_PORTS-1:0]            req;
   logic [NUM_PORTS-1:0]            we;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] wdata;
   logic [NUM_PORTS*LANES-1:0]      wmask;
   logic [NUM_PORTS-1:0]            gnt;
   logic [NUM_PORTS-1:0]            rvalid;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;
   logic                            init_busy;
   modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata, init_busy);
   modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata, init_busy);
endinterface

// File: rtl/para_ram_banked.sv
// para_ram_banked: multi-port interleaved-bank RAM with byte masks, per-bank round-robin
// arbitration and a hardware clear sweep after every reset.
module para_ram_banked #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 24,
   parameter int NUM_PORTS  = 2,
   parameter int BANK_BITS  = 2
) (
   input logic              clk,
   input logic              rst_n,
   para_ram_banked_if.slave bus
);
   localparam int NB    = 1 << BANK_BITS;
   localparam int RB    = ADDR_WIDTH - BANK_BITS;
   localparam int ROWS  = 1 << RB;
   localparam int LANES = DATA_WIDTH / 8;
   localparam int PW    = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t                          state_q, state_d;
   logic [RB-1:0]                   cnt_q, cnt_d;
   logic [PW-1:0]                   ptr_q [NB];
   logic [PW-1:0]                   win_p [NB];
   logic [NB-1:0]                   win_v;
   logic [BANK_BITS-1:0]            bk [NUM_PORTS];
   logic [RB-1:0]                   rw [NUM_PORTS];
   logic [DATA_WIDTH-1:0]           mem_q [NB][ROWS];
   logic [NUM_PORTS-1:0]            gnt, rvalid_q;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
   logic                            run;

   assign run           = state_q == RUN && rst_n;
   assign bus.gnt       = gnt;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.init_busy = state_q == INIT || !rst_n;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == RB'(ROWS - 1) ? RUN : INIT;
      end
   end

   // Round-robin: first search ports at or above the pointer, then wrap to those below it.
   always_comb begin
      win_v = '0;
      gnt   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         bk[p] = bus.addr[p*ADDR_WIDTH +: BANK_BITS];
         rw[p] = bus.addr[p*ADDR_WIDTH+BANK_BITS +: RB];
      end
      for (int b = 0; b < NB; b++) begin
         win_p[b] = '0;
         for (int p = 0; p < NUM_PORTS; p++)
            if (!win_v[b] && bus.req[p] && bk[p] == BANK_BITS'(b) && PW'(p) >= ptr_q[b]) begin
               win_v[b] = 1'b1;
               win_p[b] = PW'(p);
            end
         for (int p = 0; p < NUM_PORTS; p++)
            if (!win_v[b] && bus.req[p] && bk[p] == BANK_BITS'(b) && PW'(p) < ptr_q[b]) begin
               win_v[b] = 1'b1;
               win_p[b] = PW'(p);
            end
      end
      for (int p = 0; p < NUM_PORTS; p++)
         gnt[p] = run && win_v[bk[p]] && win_p[bk[p]] == PW'(p);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         for (int b = 0; b < NB; b++)
            ptr_q[b] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_q[p] <= gnt[p] && !bus.we[p];
            if (gnt[p] && !bus.we[p])
               rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= mem_q[bk[p]][rw[p]];
         end
         for (int b = 0; b < NB; b++)
            if (run && win_v[b])
               ptr_q[b] <= win_p[b] == PW'(NUM_PORTS - 1) ? '0 : win_p[b] + 1'b1;
      end
   end

   // At most one port owns a bank per cycle, so write targets never collide.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         for (int b = 0; b < NB; b++)
            mem_q[b][cnt_q] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++)
            for (int l = 0; l < LANES; l++)
               if (gnt[p] && bus.we[p] && bus.wmask[p*LANES+l])
                  mem_q[bk[p]][rw[p]][8*l +: 8] <= bus.wdata[p*DATA_WIDTH+8*l +: 8];
      end
   end
endmodule

// File: tb/tb_para_ram_banked.sv
// tb_para_ram_banked: directed plan steps plus random traffic checked against a
// word-array reference model with per-bank round-robin pointers.
module tb_para_ram_banked;
   localparam int AW = 6, DW = 24, NP = 2, BB = 2, NB = 4, ROWS = 16, LN = 3, DEPTH = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   para_ram_banked_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();
   para_ram_banked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .BANK_BITS(BB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   logic          r_req [NP];
   logic          r_we  [NP];
   logic [AW-1:0] r_addr[NP];
   logic [DW-1:0] r_wd  [NP];
   logic [LN-1:0] r_wm  [NP];
   logic [DW-1:0] m_mem [DEPTH];
   int            m_ptr [NB];
   logic [DW-1:0] m_rd  [NP];
   logic [NP-1:0] m_rv;
   int            m_sweep = ROWS;
   logic [NP-1:0] eg;
   logic [NP-1:0] g_obs;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd(int p);
      return bus.rdata[p*DW +: DW];
   endfunction

   task automatic setp(int p, logic rq, logic w, int a, logic [DW-1:0] d, logic [LN-1:0] m);
      r_req[p] = rq; r_we[p] = w; r_addr[p] = AW'(a); r_wd[p] = d; r_wm[p] = m;
   endtask

   task automatic idle();
      for (int p = 0; p < NP; p++) setp(p, 1'b0, 1'b0, 0, '0, '0);
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         bus.req[p] = r_req[p];
         bus.we[p] = r_we[p];
         bus.addr[p*AW +: AW] = r_addr[p];
         bus.wdata[p*DW +: DW] = r_wd[p];
         bus.wmask[p*LN +: LN] = r_wm[p];
      end
   endtask

   // Winner per bank is the requester closest to the bank pointer going upward modulo NP.
   task automatic calc_gnt();
      eg = '0;
      if (!rst_n || m_sweep > 0) return;
      for (int b = 0; b < NB; b++) begin
         int win = -1;
         int bd = NP;
         for (int p = 0; p < NP; p++)
            if (r_req[p] && int'(r_addr[p]) % NB == b) begin
               int d = (p - m_ptr[b] + NP) % NP;
               if (d < bd) begin bd = d; win = p; end
            end
         if (win >= 0) eg[win] = 1'b1;
      end
   endtask

   task automatic cyc();
      drive();
      #1;
      calc_gnt();
      g_obs = bus.gnt;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("init_busy", 32'(bus.init_busy), 32'(!rst_n || m_sweep > 0));
      @(posedge clk);
      #1;
      if (!rst_n) begin
         for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
         for (int b = 0; b < NB; b++) m_ptr[b] = 0;
         for (int p = 0; p < NP; p++) m_rd[p] = '0;
         m_rv = '0;
         m_sweep = ROWS;
      end else if (m_sweep > 0) begin
         m_sweep--;
         m_rv = '0;
      end else begin
         m_rv = '0;
         for (int p = 0; p < NP; p++)
            if (eg[p] && !r_we[p]) begin
               m_rd[p] = m_mem[r_addr[p]];
               m_rv[p] = 1'b1;
            end
         for (int p = 0; p < NP; p++) begin
            if (eg[p] && r_we[p])
               for (int l = 0; l < LN; l++)
                  if (r_wm[p][l]) m_mem[r_addr[p]][8*l +: 8] = r_wd[p][8*l +: 8];
            if (eg[p]) m_ptr[int'(r_addr[p]) % NB] = (p + 1) % NP;
         end
      end
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rvalid%0d", p), 32'(bus.rvalid[p]), 32'(m_rv[p]));
         chk($sformatf("rdata%0d", p), 32'(rd(p)), 32'(m_rd[p]));
      end
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (ROWS) cyc();
      chk("busy_low_after_sweep", 32'(bus.init_busy), 32'd0);

      for (int a = 0; a < DEPTH; a += 2) begin
         setp(0, 1'b1, 1'b1, a, 24'hABCDEF, 3'b111);
         setp(1, 1'b1, 1'b1, a + 1, 24'hABCDEF, 3'b111);
         cyc();
      end
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      setp(0, 1'b1, 1'b0, 3, '0, '0);
      setp(1, 1'b1, 1'b0, 8, '0, '0);
      repeat (ROWS) cyc();
      for (int a = 0; a < DEPTH; a += 2) begin
         setp(0, 1'b1, 1'b0, a, '0, '0);
         setp(1, 1'b1, 1'b0, a + 1, '0, '0);
         cyc();
         chk("clear_rd0", 32'(rd(0)), 32'd0);
         chk("clear_rd1", 32'(rd(1)), 32'd0);
      end

      idle();
      setp(0, 1'b1, 1'b1, 5, 24'h123456, 3'b111);
      cyc();
      setp(0, 1'b1, 1'b1, 5, 24'hFFFFFF, 3'b010);
      cyc();
      setp(0, 1'b1, 1'b0, 5, '0, '0);
      cyc();
      chk("masked", 32'(rd(0)), 32'h12FF56);

      setp(0, 1'b1, 1'b0, 4, '0, '0);
      setp(1, 1'b1, 1'b1, 1, 24'h5A5A5A, 3'b111);
      cyc();
      chk("parallel_gnt", 32'(g_obs), 32'b11);
      chk("parallel_rv0", 32'(bus.rvalid[0]), 32'd1);

      idle();
      setp(1, 1'b1, 1'b1, 2, 24'h222222, 3'b111);
      cyc();
      setp(1, 1'b1, 1'b1, 6, 24'h666666, 3'b111);
      cyc();
      setp(0, 1'b1, 1'b0, 2, '0, '0);
      setp(1, 1'b1, 1'b0, 6, '0, '0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_gnt", 32'(g_obs), (i % 2) ? 32'b10 : 32'b01);
         chk("rr_rdata", 32'(rd(i % 2)), (i % 2) ? 32'h666666 : 32'h222222);
      end

      idle();
      setp(0, 1'b1, 1'b1, 9, 24'h00AA55, 3'b111);
      cyc();
      idle();
      setp(1, 1'b1, 1'b0, 9, '0, '0);
      cyc();
      chk("raw", 32'(rd(1)), 32'h00AA55);

      idle();
      setp(0, 1'b1, 1'b0, 5, '0, '0);
      cyc();
      chk("pre_rst_rv", 32'(bus.rvalid[0]), 32'd1);
      rst_n = 1'b0;
      cyc();
      chk("rst_rv", 32'(bus.rvalid), 32'd0);
      chk("rst_rd0", 32'(rd(0)), 32'd0);
      rst_n = 1'b1;
      setp(1, 1'b1, 1'b0, 5, '0, '0);
      repeat (ROWS) cyc();

      idle();
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < NP; p++)
            if (!r_req[p] || eg[p])
               setp(p, $urandom % 4 != 0, 1'($urandom % 2),
                    ($urandom % 2) ? int'($urandom % 8) : int'($urandom % DEPTH),
                    DW'($urandom), LN'($urandom % 8));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/para_ram_banked.md
# para_ram_banked

Multi-port, multi-bank successor to the single-port user-area SRAM. It serves NUM_PORTS independent request channels over 2^BANK_BITS interleaved banks, with masked byte writes and per-bank round-robin conflict arbitration. After every reset it clears all contents to zero in hardware. It sits behind the user-project pad/bus glue, which flattens the per-port buses onto the ports below.

## Interface
- ADDR_WIDTH, 6, word address width; total depth 2^ADDR_WIDTH words.
- DATA_WIDTH, 24, word width; must be a multiple of 8.
- NUM_PORTS, 2, number of request channels; valid range 1–4.
- BANK_BITS, 2, log2 of the bank count; must be less than ADDR_WIDTH.
- Derived values:
  - NB = 2^BANK_BITS banks.
  - ROWS = 2^(ADDR_WIDTH-BANK_BITS) rows per bank.
  - LANES = DATA_WIDTH/8 byte lanes.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_PORTS  per-port request valid.
- we  in  NUM_PORTS  per-port write (1) or read (0).
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port word address; port p uses slice p.
- wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- wmask  in  NUM_PORTS*LANES  per-port byte-lane enable; bit i covers bits 8i+7:8i.
- gnt  out  NUM_PORTS  combinational grant; a transfer occurs on an edge where req&gnt=1.
- rvalid  out  NUM_PORTS  registered read-data valid.
- rdata  out  NUM_PORTS*DATA_WIDTH  registered read data.
- init_busy  out  1  high while reset or the clear sweep is active.

## Operation
- Address map:
  - bank = addr[BANK_BITS-1:0]
  - row = addr[ADDR_WIDTH-1:BANK_BITS]
  - Consecutive addresses fall in different banks.
- FSM has two states, INIT and RUN.
  - rst_n=0 at an edge forces INIT with row counter = 0.
  - INIT: each edge writes zero to row counter in every bank, then increments the counter. After writing row ROWS-1 the FSM enters RUN.
  - RUN persists until the next reset.
- In INIT, gnt is all zeros and requests are ignored.
- Arbitration in RUN is independent per bank.
  - Each bank grants at most one of the ports whose req=1 and whose addr maps to that bank.
  - Ports targeting different banks are all granted in the same cycle.
  - Each bank keeps a round-robin pointer, reset to 0. Priority order is ptr, ptr+1, … mod NUM_PORTS.
  - On a grant, that bank's pointer becomes winner+1 mod NUM_PORTS. Pointers of banks that granted nothing hold.
- Requester rule: req, we, addr, wdata and wmask are held stable until gnt. gnt depends only on the current inputs and state; there is no combinational path from rdata.
- Write (req&gnt&we): at the edge, only the lanes with wmask=1 are updated. wmask=0 is accepted as a no-op.
- Read (req&gnt&~we): at the edge, rdata[p] loads the bank word and rvalid[p]=1 for one cycle. Back-to-back grants give rvalid high continuously.
- Without a read grant, rvalid[p]=0 and rdata[p] holds its last value.
- Read-after-write: a read granted on the edge after a write to the same address returns the new data. A same-cycle same-address conflict cannot occur, because the bank grants one port only.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, init_busy=1, all bank pointers=0.
- Reset during RUN:
  - In-flight rvalid is dropped at the reset edge.
  - Memory is re-cleared by the INIT sweep.
  - Pointers return to 0.
- Reset during INIT restarts the sweep at row 0.
- After rst_n rises, the clear sweep takes exactly ROWS edges (16 at defaults).
- init_busy falls on the cycle following the ROWS-th edge; gnt can assert in that same cycle.
- Read latency: one edge from grant to rvalid/rdata.
- Write latency: data is visible to a read granted on the next edge.
- Throughput: one transfer per port per cycle when the ports hit distinct banks.
- Conflicts: with NUM_PORTS ports all contending for one bank, each port is granted within NUM_PORTS cycles.

## Test plan
- Reset and clear:
  - Stimulus: write 0xABCDEF to every address; pulse rst_n low 1 cycle; then read all 64 addresses.
  - Required: init_busy is high for 16 cycles after release; every read returns 0x000000 with rvalid one cycle after gnt.
- Masked write:
  - Stimulus: write 0x123456 to addr 5 with mask 3'b111; write 0xFFFFFF with mask 3'b010; read addr 5.
  - Required: rdata=0x12FF56.
- Parallel banks:
  - Stimulus: port0 reads addr 4 (bank 0) while port1 writes addr 1 (bank 1) in the same cycle.
  - Required: gnt=2'b11; port0 rvalid on the next cycle.
- Conflict round-robin:
  - Stimulus: both ports hold reads to bank 2 (addr 2 and addr 6) continuously.
  - Required: gnt alternates 01, 10, 01…; each rdata matches its address.
- Read-after-write:
  - Stimulus: port0 writes 0x00AA55 to addr 9; port1 reads addr 9 on the next cycle.
  - Required: port1 rdata=0x00AA55.
- Reset mid-read:
  - Stimulus: assert rst_n=0 on the edge following a read grant.
  - Required: rvalid=0 and rdata=0 after that edge; gnt=0 until the sweep completes.
